qtable_update_ctrl: RTL and testbench

- Sequencer for the neighbor Q-table banks (neighborID, clusterID, energyLeft, qValue) and the knownCH bank.
- On each received packet it scans the neighbor table for the sender. It then updates the matching entry or appends a new one.
- For cluster-head announcements it also inserts the sender into the known-CH list if the sender is absent.
- Sits between the packet parser and the memory banks; it is the only writer of those banks.

---
 rtl/qtable_update_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_qtable_update_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/qtable_update_ctrl.sv
// qtable_update_ctrl: scans the neighbor Q-table and known-CH list per received packet and issues the single update/append write to each
module qtable_update_ctrl #(
  parameter int WORD_WIDTH    = 16,
  parameter int MAX_NEIGHBORS = 32,
  parameter int MAX_CH        = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [WORD_WIDTH-1:0] fSourceID,
  input  logic [WORD_WIDTH-1:0] fClusterID,
  input  logic [WORD_WIDTH-1:0] fEnergyLeft,
  input  logic [WORD_WIDTH-1:0] fQValue,
  input  logic [2:0]            fPacketType,
  input  logic [WORD_WIDTH-1:0] mSourceID,
  input  logic [WORD_WIDTH-1:0] mKnownCH,
  output logic [WORD_WIDTH-1:0] neighborIndex,
  output logic [WORD_WIDTH-1:0] nodeID,
  output logic [WORD_WIDTH-1:0] nodeClusterID,
  output logic [WORD_WIDTH-1:0] nodeEnergy,
  output logic [WORD_WIDTH-1:0] nodeQValue,
  output logic                  nbr_wr_en,
  output logic [WORD_WIDTH-1:0] knownCHIndex,
  output logic [WORD_WIDTH-1:0] knownCH,
  output logic                  ch_wr_en,
  output logic [WORD_WIDTH-1:0] neighborCount,
  output logic [WORD_WIDTH-1:0] knownCHCount,
  output logic                  busy,
  output logic                  done,
  output logic                  nbr_full,
  output logic                  ch_full
);
  typedef enum logic [2:0] {IDLE, NB_RD, NB_CMP, NB_WR, CH_RD, CH_CMP, CH_WR, DONE} state_t;
  state_t state_q, state_d;
  logic [WORD_WIDTH-1:0] src_q, src_d, cid_q, cid_d, egy_q, egy_d, qv_q, qv_d;
  logic [2:0] typ_q, typ_d;
  logic [WORD_WIDTH-1:0] nidx_q, nidx_d, cidx_q, cidx_d, kch_q, kch_d, ncnt_q, ncnt_d, ccnt_q, ccnt_d;
  logic [WORD_WIDTH-1:0] nid_q, nid_d, ncid_q, ncid_d, negy_q, negy_d, nqv_q, nqv_d;
  logic app_q, app_d, nfull_q, nfull_d, cfull_q, cfull_d, to_nbwr, to_phase;
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    cid_d = cid_q;
    egy_d = egy_q;
    qv_d = qv_q;
    typ_d = typ_q;
    nidx_d = nidx_q;
    cidx_d = cidx_q;
    kch_d = kch_q;
    ncnt_d = ncnt_q;
    ccnt_d = ccnt_q;
    nid_d = nid_q;
    ncid_d = ncid_q;
    negy_d = negy_q;
    nqv_d = nqv_q;
    app_d = app_q;
    nfull_d = nfull_q;
    cfull_d = cfull_q;
    to_nbwr = 1'b0;
    to_phase = 1'b0;
    case (state_q)
      IDLE: if (en) begin
        src_d = fSourceID;
        cid_d = fClusterID;
        egy_d = fEnergyLeft;
        qv_d = fQValue;
        typ_d = fPacketType;
        if (fPacketType != 3'd1 && fPacketType != 3'd2) state_d = DONE;
        else if (ncnt_q == '0) begin
          nidx_d = '0;
          app_d = 1'b1;
          to_nbwr = 1'b1;
        end else begin
          nidx_d = '0;
          state_d = NB_RD;
        end
      end
      NB_RD: state_d = NB_CMP;
      NB_CMP: if (mSourceID == src_q) begin
        app_d = 1'b0;
        to_nbwr = 1'b1;
      end else if (nidx_q + WORD_WIDTH'(1) < ncnt_q) begin
        nidx_d = nidx_q + WORD_WIDTH'(1);
        state_d = NB_RD;
      end else if (ncnt_q < WORD_WIDTH'(MAX_NEIGHBORS)) begin
        nidx_d = ncnt_q;
        app_d = 1'b1;
        to_nbwr = 1'b1;
      end else begin
        nfull_d = 1'b1;
        to_phase = 1'b1;
      end
      NB_WR: begin
        ncnt_d = app_q ? ncnt_q + WORD_WIDTH'(1) : ncnt_q;
        to_phase = 1'b1;
      end
      CH_RD: state_d = CH_CMP;
      CH_CMP: if (mKnownCH == src_q) state_d = DONE;
      else if (cidx_q + WORD_WIDTH'(1) < ccnt_q) begin
        cidx_d = cidx_q + WORD_WIDTH'(1);
        state_d = CH_RD;
      end else if (ccnt_q < WORD_WIDTH'(MAX_CH)) begin
        cidx_d = ccnt_q;
        kch_d = src_q;
        state_d = CH_WR;
      end else begin
        cfull_d = 1'b1;
        state_d = DONE;
      end
      CH_WR: begin
        ccnt_d = ccnt_q + WORD_WIDTH'(1);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (to_nbwr) begin
      state_d = NB_WR;
      nid_d = src_d;
      ncid_d = cid_d;
      negy_d = egy_d;
      nqv_d = qv_d;
    end
    if (to_phase) begin
      if (typ_q == 3'd2) begin
        cidx_d = '0;
        if (ccnt_q == '0) begin
          kch_d = src_q;
          state_d = CH_WR;
        end else state_d = CH_RD;
      end else state_d = DONE;
    end
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q <= IDLE;
      src_q <= '0;
      cid_q <= '0;
      egy_q <= '0;
      qv_q <= '0;
      typ_q <= '0;
      nidx_q <= '0;
      cidx_q <= '0;
      kch_q <= '0;
      ncnt_q <= '0;
      ccnt_q <= '0;
      nid_q <= '0;
      ncid_q <= '0;
      negy_q <= '0;
      nqv_q <= '0;
      app_q <= 1'b0;
      nfull_q <= 1'b0;
      cfull_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      cid_q <= cid_d;
      egy_q <= egy_d;
      qv_q <= qv_d;
      typ_q <= typ_d;
      nidx_q <= nidx_d;
      cidx_q <= cidx_d;
      kch_q <= kch_d;
      ncnt_q <= ncnt_d;
      ccnt_q <= ccnt_d;
      nid_q <= nid_d;
      ncid_q <= ncid_d;
      negy_q <= negy_d;
      nqv_q <= nqv_d;
      app_q <= app_d;
      nfull_q <= nfull_d;
      cfull_q <= cfull_d;
    end
  assign neighborIndex = nidx_q;
  assign nodeID = nid_q;
  assign nodeClusterID = ncid_q;
  assign nodeEnergy = negy_q;
  assign nodeQValue = nqv_q;
  assign nbr_wr_en = state_q == NB_WR;
  assign knownCHIndex = cidx_q;
  assign knownCH = kch_q;
  assign ch_wr_en = state_q == CH_WR;
  assign neighborCount = ncnt_q;
  assign knownCHCount = ccnt_q;
  assign busy = state_q != IDLE && state_q != DONE;
  assign done = state_q == DONE;
  assign nbr_full = nfull_q;
  assign ch_full = cfull_q;
endmodule

// File: tb/tb_qtable_update_ctrl.sv
// tb_qtable_update_ctrl: directed self-checking bench with bank models for qtable_update_ctrl
module tb_qtable_update_ctrl;
  logic clk = 1'b0, nrst, en;
  logic [15:0] fSourceID, fClusterID, fEnergyLeft, fQValue, mSourceID, mKnownCH;
  logic [2:0] fPacketType;
  logic [15:0] neighborIndex, nodeID, nodeClusterID, nodeEnergy, nodeQValue, knownCHIndex, knownCH;
  logic [15:0] neighborCount, knownCHCount;
  logic nbr_wr_en, ch_wr_en, busy, done, nbr_full, ch_full;
  logic [15:0] nid_mem [64];
  logic [15:0] kch_mem [64];
  int errs = 0, checks = 0, lat, nwr, cwr, both;
  logic [15:0] widx, wE, wQ, cidx, kch;
  qtable_update_ctrl dut (
    .clk(clk), .nrst(nrst), .en(en), .fSourceID(fSourceID), .fClusterID(fClusterID),
    .fEnergyLeft(fEnergyLeft), .fQValue(fQValue), .fPacketType(fPacketType),
    .mSourceID(mSourceID), .mKnownCH(mKnownCH), .neighborIndex(neighborIndex), .nodeID(nodeID),
    .nodeClusterID(nodeClusterID), .nodeEnergy(nodeEnergy), .nodeQValue(nodeQValue),
    .nbr_wr_en(nbr_wr_en), .knownCHIndex(knownCHIndex), .knownCH(knownCH), .ch_wr_en(ch_wr_en),
    .neighborCount(neighborCount), .knownCHCount(knownCHCount), .busy(busy), .done(done),
    .nbr_full(nbr_full), .ch_full(ch_full)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (nbr_wr_en) nid_mem[neighborIndex[5:0]] <= nodeID;
    if (ch_wr_en) kch_mem[knownCHIndex[5:0]] <= knownCH;
    mSourceID <= nid_mem[neighborIndex[5:0]];
    mKnownCH <= kch_mem[knownCHIndex[5:0]];
  end
  task automatic send(input logic [15:0] id, input logic [15:0] e, input logic [15:0] q, input logic [2:0] t);
    logic seen;
    @(negedge clk);
    fSourceID = id;
    fClusterID = id + 16'd1000;
    fEnergyLeft = e;
    fQValue = q;
    fPacketType = t;
    en = 1'b1;
    nwr = 0;
    cwr = 0;
    both = 0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 300) begin
      @(posedge clk);
      #1;
      en = 1'b0;
      lat++;
      if (nbr_wr_en) begin
        nwr++;
        widx = neighborIndex;
        wE = nodeEnergy;
        wQ = nodeQValue;
      end
      if (ch_wr_en) begin
        cwr++;
        cidx = knownCHIndex;
        kch = knownCH;
      end
      if (nbr_wr_en && ch_wr_en) both = 1;
      seen = done;
    end
    checks++;
    if (!seen) begin
      errs++;
      $display("FAIL done_timeout id=%0d: got no done within %0d cycles", id, lat);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    checks++;
    if ({busy, done, nbr_wr_en, ch_wr_en, nbr_full, ch_full} !== 6'b0) begin
      errs++;
      $display("FAIL reset_flags: got %b, want 000000", {busy, done, nbr_wr_en, ch_wr_en, nbr_full, ch_full});
    end
    checks++;
    if ({neighborCount, knownCHCount, neighborIndex, nodeID} !== 64'd0) begin
      errs++;
      $display("FAIL reset_words: got %h, want 0", {neighborCount, knownCHCount, neighborIndex, nodeID});
    end
  endtask
  task automatic test_first_hello;
    send(16'd5, 16'd100, 16'd7, 3'd1);
    checks++;
    if (lat !== 2) begin errs++; $display("FAIL first_lat: got %0d, want 2", lat); end
    checks++;
    if (nwr !== 1 || widx !== 16'd0 || wE !== 16'd100 || wQ !== 16'd7) begin
      errs++;
      $display("FAIL first_write: got n=%0d idx=%0d E=%0d Q=%0d, want 1 0 100 7", nwr, widx, wE, wQ);
    end
    checks++;
    if (neighborCount !== 16'd1) begin errs++; $display("FAIL first_count: got %0d, want 1", neighborCount); end
  endtask
  task automatic test_update;
    send(16'd5, 16'd90, 16'd8, 3'd1);
    checks++;
    if (lat !== 4) begin errs++; $display("FAIL update_lat: got %0d, want 4", lat); end
    checks++;
    if (nwr !== 1 || widx !== 16'd0 || wE !== 16'd90) begin
      errs++;
      $display("FAIL update_write: got n=%0d idx=%0d E=%0d, want 1 0 90", nwr, widx, wE);
    end
    checks++;
    if (neighborCount !== 16'd1) begin errs++; $display("FAIL update_count: got %0d, want 1", neighborCount); end
  endtask
  task automatic test_append;
    send(16'd6, 16'd50, 16'd1, 3'd1);
    checks++;
    if (lat !== 4 || widx !== 16'd1) begin errs++; $display("FAIL append6: got lat=%0d idx=%0d, want 4 1", lat, widx); end
    send(16'd7, 16'd50, 16'd1, 3'd1);
    checks++;
    if (lat !== 6 || widx !== 16'd2) begin errs++; $display("FAIL append7: got lat=%0d idx=%0d, want 6 2", lat, widx); end
    send(16'd9, 16'd50, 16'd1, 3'd1);
    checks++;
    if (lat !== 8) begin errs++; $display("FAIL append9_lat: got %0d, want 8", lat); end
    checks++;
    if (nwr !== 1 || widx !== 16'd3 || neighborCount !== 16'd4) begin
      errs++;
      $display("FAIL append9: got n=%0d idx=%0d cnt=%0d, want 1 3 4", nwr, widx, neighborCount);
    end
  endtask
  task automatic test_ch;
    send(16'd6, 16'd40, 16'd2, 3'd2);
    checks++;
    if (lat !== 7) begin errs++; $display("FAIL ch1_lat: got %0d, want 7", lat); end
    checks++;
    if (cwr !== 1 || cidx !== 16'd0 || kch !== 16'd6 || knownCHCount !== 16'd1) begin
      errs++;
      $display("FAIL ch1_insert: got n=%0d idx=%0d kch=%0d cnt=%0d, want 1 0 6 1", cwr, cidx, kch, knownCHCount);
    end
    checks++;
    if (nwr !== 1 || widx !== 16'd1 || both !== 0) begin
      errs++;
      $display("FAIL ch1_nbr: got n=%0d idx=%0d both=%0d, want 1 1 0", nwr, widx, both);
    end
    send(16'd6, 16'd41, 16'd2, 3'd2);
    checks++;
    if (lat !== 8 || cwr !== 0 || knownCHCount !== 16'd1) begin
      errs++;
      $display("FAIL ch2_match: got lat=%0d n=%0d cnt=%0d, want 8 0 1", lat, cwr, knownCHCount);
    end
  endtask
  task automatic test_nbr_full;
    for (int i = 0; i < 28; i++) send(16'd100 + 16'(i), 16'd10, 16'd1, 3'd1);
    checks++;
    if (neighborCount !== 16'd32 || nbr_full !== 1'b0) begin
      errs++;
      $display("FAIL fill32: got cnt=%0d full=%b, want 32 0", neighborCount, nbr_full);
    end
    send(16'd200, 16'd10, 16'd1, 3'd1);
    checks++;
    if (nwr !== 0 || nbr_full !== 1'b1 || neighborCount !== 16'd32) begin
      errs++;
      $display("FAIL overflow33: got n=%0d full=%b cnt=%0d, want 0 1 32", nwr, nbr_full, neighborCount);
    end
    checks++;
    if (lat !== 65) begin errs++; $display("FAIL overflow33_lat: got %0d, want 65", lat); end
  endtask
  task automatic test_other_type;
    send(16'd5, 16'd1, 16'd1, 3'd3);
    checks++;
    if (lat !== 1 || nwr !== 0 || cwr !== 0) begin
      errs++;
      $display("FAIL type3: got lat=%0d nw=%0d cw=%0d, want 1 0 0", lat, nwr, cwr);
    end
    checks++;
    if (neighborCount !== 16'd32 || knownCHCount !== 16'd1) begin
      errs++;
      $display("FAIL type3_counts: got %0d %0d, want 32 1", neighborCount, knownCHCount);
    end
  endtask
  task automatic test_ch_full;
    for (int i = 0; i < 7; i++) send(16'd300 + 16'(i), 16'd10, 16'd1, 3'd2);
    checks++;
    if (knownCHCount !== 16'd8 || ch_full !== 1'b0) begin
      errs++;
      $display("FAIL ch_fill8: got cnt=%0d full=%b, want 8 0", knownCHCount, ch_full);
    end
    send(16'd307, 16'd10, 16'd1, 3'd2);
    checks++;
    if (cwr !== 0 || ch_full !== 1'b1 || knownCHCount !== 16'd8 || nbr_full !== 1'b1) begin
      errs++;
      $display("FAIL ch_overflow: got n=%0d chf=%b cnt=%0d nbf=%b, want 0 1 8 1", cwr, ch_full, knownCHCount, nbr_full);
    end
  endtask
  task automatic test_reset_mid;
    @(negedge clk);
    fSourceID = 16'd400;
    fPacketType = 3'd1;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errs++; $display("FAIL mid_busy: got %b, want 1", busy); end
    nrst = 1'b0;
    #1;
    checks++;
    if ({busy, nbr_wr_en, ch_wr_en, nbr_full, ch_full} !== 5'b0 || neighborCount !== 16'd0 || knownCHCount !== 16'd0) begin
      errs++;
      $display("FAIL mid_reset: got flags=%b cnt=%0d ch=%0d, want 0 0 0", {busy, nbr_wr_en, ch_wr_en, nbr_full, ch_full}, neighborCount, knownCHCount);
    end
    @(negedge clk);
    nrst = 1'b1;
    send(16'd5, 16'd100, 16'd7, 3'd1);
    checks++;
    if (lat !== 2 || neighborCount !== 16'd1) begin
      errs++;
      $display("FAIL post_reset: got lat=%0d cnt=%0d, want 2 1", lat, neighborCount);
    end
  endtask
  initial begin
    nrst = 1'b0;
    en = 1'b0;
    fSourceID = '0;
    fClusterID = '0;
    fEnergyLeft = '0;
    fQValue = '0;
    fPacketType = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    nrst = 1'b1;
    test_first_hello;
    test_update;
    test_append;
    test_ch;
    test_nbr_full;
    test_other_type;
    test_ch_full;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
